text_cursor_ctrl: RTL and testbench

Keyboard-to-display write sequencer. It sits between `keyboard_wrapper` (`char_data`/`char_ready`) and the `vga_wrapper` character write port (`vga_char_wr`/`vga_char_in`/`vga_char_x`/`vga_char_y`), and it owns the text cursor. It turns decoded characters into single-cell writes, handles newline, backspace and clear-screen, and performs multi-cycle row and screen clears, buffering one character while busy.

---
 rtl/text_cursor_ctrl.sv | 179 +++++++++++++++++
 tb/tb_text_cursor_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_ctrl.sv
// Keyboard-to-display write sequencer: turns decoded characters into VGA text-cell writes,
// owns the cursor and runs multi-cycle row/screen clears with a one-entry pending slot.
module text_cursor_ctrl #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       char_ready,
    input  logic [7:0] char_data,
    output logic       vga_char_wr,
    output logic [7:0] vga_char_in,
    output logic [6:0] vga_char_x,
    output logic [4:0] vga_char_y,
    output logic [6:0] cursor_x,
    output logic [4:0] cursor_y,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam logic [6:0] LastCol = 7'(COLS - 1);
    localparam logic [4:0] LastRow = 5'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StClrRow, StClrAll} state_e;

    state_e     state_q, state_d;
    logic [6:0] cx_q, cx_d, c_q, c_d, wx_q, wx_d;
    logic [4:0] cy_q, cy_d, r_q, r_d, wy_q, wy_d;
    logic [7:0] pend_q, pend_d, drop_q, drop_d, wch_q, wch_d;
    logic       pend_v_q, pend_v_d, wr_q, wr_d;

    logic       src_v;
    logic [7:0] src;
    logic [4:0] next_row;

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        c_d      = c_q;
        r_d      = r_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        drop_d   = drop_q;
        wr_d     = 1'b0;
        wch_d    = wch_q;
        wx_d     = wx_q;
        wy_d     = wy_q;

        // The pending slot always has priority over a fresh strobe.
        src_v    = (state_q == StIdle) && (pend_v_q || char_ready);
        src      = pend_v_q ? pend_q : char_data;
        next_row = (cy_q == LastRow) ? 5'd0 : cy_q + 5'd1;

        case (state_q)
            StIdle: begin
                if (src_v) begin
                    if (src >= 8'h20 && src <= 8'h7E) begin
                        wr_d  = 1'b1;
                        wch_d = src;
                        wx_d  = cx_q;
                        wy_d  = cy_q;
                        if (cx_q < LastCol) begin
                            cx_d = cx_q + 7'd1;
                        end else begin
                            cx_d    = 7'd0;
                            cy_d    = next_row;
                            c_d     = 7'd0;
                            state_d = StClrRow;
                        end
                    end else if (src == 8'h0A || src == 8'h0D) begin
                        cx_d    = 7'd0;
                        cy_d    = next_row;
                        c_d     = 7'd0;
                        state_d = StClrRow;
                    end else if (src == 8'h08) begin
                        if (cx_q != 7'd0) begin
                            cx_d  = cx_q - 7'd1;
                            wr_d  = 1'b1;
                            wch_d = 8'h20;
                            wx_d  = cx_q - 7'd1;
                            wy_d  = cy_q;
                        end else if (cy_q != 5'd0) begin
                            cx_d  = LastCol;
                            cy_d  = cy_q - 5'd1;
                            wr_d  = 1'b1;
                            wch_d = 8'h20;
                            wx_d  = LastCol;
                            wy_d  = cy_q - 5'd1;
                        end
                    end else if (src == 8'h1B) begin
                        cx_d    = 7'd0;
                        cy_d    = 5'd0;
                        c_d     = 7'd0;
                        r_d     = 5'd0;
                        state_d = StClrAll;
                    end
                end
            end
            StClrRow: begin
                wr_d  = 1'b1;
                wch_d = 8'h20;
                wx_d  = c_q;
                wy_d  = cy_q;
                if (c_q == LastCol) state_d = StIdle;
                else                c_d     = c_q + 7'd1;
            end
            StClrAll: begin
                wr_d  = 1'b1;
                wch_d = 8'h20;
                wx_d  = c_q;
                wy_d  = r_q;
                if (c_q == LastCol) begin
                    c_d = 7'd0;
                    if (r_q == LastRow) state_d = StIdle;
                    else                r_d     = r_q + 5'd1;
                end else begin
                    c_d = c_q + 7'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Slot bookkeeping: in idle a full slot is drained this edge, so it can refill.
        if (state_q == StIdle) begin
            if (pend_v_q) begin
                pend_v_d = char_ready;
                if (char_ready) pend_d = char_data;
            end
        end else if (char_ready) begin
            if (!pend_v_q) begin
                pend_v_d = 1'b1;
                pend_d   = char_data;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cx_q     <= '0;
            cy_q     <= '0;
            c_q      <= '0;
            r_q      <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            drop_q   <= '0;
            wr_q     <= 1'b0;
            wch_q    <= '0;
            wx_q     <= '0;
            wy_q     <= '0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            c_q      <= c_d;
            r_q      <= r_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            drop_q   <= drop_d;
            wr_q     <= wr_d;
            wch_q    <= wch_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
        end
    end

    assign vga_char_wr = wr_q;
    assign vga_char_in = wch_q;
    assign vga_char_x  = wx_q;
    assign vga_char_y  = wy_q;
    assign cursor_x    = cx_q;
    assign cursor_y    = cy_q;
    assign busy        = (state_q != StIdle);
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl: expected VGA writes are queued as stimulus is
// driven and compared in order as the write strobe appears.
module tb_text_cursor_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       char_ready = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       vga_char_wr;
    logic [7:0] vga_char_in;
    logic [6:0] vga_char_x;
    logic [4:0] vga_char_y;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic       busy;
    logic [7:0] drop_cnt;

    int checks = 0;
    int fails  = 0;
    logic [19:0] exp_q[$];

    text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .char_ready  (char_ready),
        .char_data   (char_data),
        .vga_char_wr (vga_char_wr),
        .vga_char_in (vga_char_in),
        .vga_char_x  (vga_char_x),
        .vga_char_y  (vga_char_y),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_write(input logic [7:0] ch, input int x, input int y);
        exp_q.push_back({ch, 7'(x), 5'(y)});
    endtask

    task automatic push_row_clear(input int y);
        for (int x = 0; x < COLS; x++) push_write(8'h20, x, y);
    endtask

    // Called at a negedge; holds the strobe for one cycle and returns at the next negedge.
    task automatic send(input logic [7:0] ch);
        char_data  = ch;
        char_ready = 1'b1;
        @(negedge clk);
        char_ready = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        check("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset_n && vga_char_wr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {12'd0, vga_char_in, vga_char_x, vga_char_y}, 32'hFFFFF);
            end else begin
                check("write", {12'd0, vga_char_in, vga_char_x, vga_char_y},
                      {12'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int cnt;

        repeat (3) @(negedge clk);
        check("rst_wr", {31'd0, vga_char_wr}, 32'd0);
        check("rst_char", {16'd0, vga_char_in, 3'd0, vga_char_y}, 32'd0);
        check("rst_x", {25'd0, vga_char_x}, 32'd0);
        check("rst_cursor", {20'd0, cursor_x, cursor_y}, 32'd0);
        check("rst_busy_drop", {23'd0, busy, drop_cnt}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Back-to-back printable characters.
        push_write(8'h41, 0, 0);
        push_write(8'h42, 1, 0);
        send(8'h41);
        send(8'h42);
        repeat (3) @(negedge clk);
        check("ab_cursor", {20'd0, cursor_x, cursor_y}, {20'd0, 7'd2, 5'd0});
        check("ab_busy", {31'd0, busy}, 32'd0);

        // Newlines down to row 3.
        for (int y = 1; y <= 3; y++) begin
            push_row_clear(y);
            send(8'h0D);
            wait_idle();
        end
        check("nl_cursor", {20'd0, cursor_x, cursor_y}, {20'd0, 7'd0, 5'd3});

        // Full line of printables wraps and clears row 4.
        for (int i = 0; i < COLS; i++) push_write(8'h30 + 8'(i % 40), i, 3);
        push_row_clear(4);
        for (int i = 0; i < COLS; i++) send(8'h30 + 8'(i % 40));
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("wrap_busy_cycles", cnt, COLS);
        repeat (3) @(negedge clk);
        check("wrap_cursor", {20'd0, cursor_x, cursor_y}, {20'd0, 7'd0, 5'd4});

        // Walk to (5,29), then CR wraps to row 0.
        for (int y = 5; y < ROWS; y++) begin
            push_row_clear(y);
            send(8'h0A);
            wait_idle();
        end
        for (int i = 0; i < 5; i++) begin
            push_write(8'h61 + 8'(i), i, 29);
            send(8'h61 + 8'(i));
        end
        repeat (2) @(negedge clk);
        check("pre_cr_cursor", {20'd0, cursor_x, cursor_y}, {20'd0, 7'd5, 5'd29});
        push_row_clear(0);
        send(8'h0D);
        wait_idle();
        check("cr_wrap_cursor", {20'd0, cursor_x, cursor_y}, 32'd0);

        // Backspace across a row boundary.
        for (int y = 1; y <= 7; y++) begin
            push_row_clear(y);
            send(8'h0A);
            wait_idle();
        end
        push_write(8'h20, 79, 6);
        send(8'h08);
        repeat (3) @(negedge clk);
        check("bs_cursor", {20'd0, cursor_x, cursor_y}, {20'd0, 7'd79, 5'd6});

        // Plain screen clear, then backspace at origin does nothing.
        for (int y = 0; y < ROWS; y++) push_row_clear(y);
        send(8'h1B);
        check("esc_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        send(8'h08);
        repeat (5) @(negedge clk);
        check("bs_origin_cursor", {20'd0, cursor_x, cursor_y}, 32'd0);
        check("bs_origin_queue", exp_q.size(), 0);

        // Screen clear with three characters arriving during it.
        for (int y = 0; y < ROWS; y++) push_row_clear(y);
        push_write(8'h78, 0, 0);
        send(8'h1B);
        repeat (10) @(negedge clk);
        send(8'h78);
        send(8'h79);
        send(8'h7A);
        cnt = 0;
        while (busy && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check("esc_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("pend_write_next", {23'd0, vga_char_wr, vga_char_in}, {23'd0, 1'b1, 8'h78});
        check("pend_write_pos", {20'd0, vga_char_x, vga_char_y}, 32'd0);
        repeat (3) @(negedge clk);
        check("drop_cnt", {24'd0, drop_cnt}, 32'd2);
        check("esc_queue", exp_q.size(), 0);

        // Reset in the middle of a row clear.
        push_row_clear(1);
        send(8'h0D);
        repeat (40) @(negedge clk);
        #1;
        check("mid_clear_written", exp_q.size(), COLS - 40);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr_busy", {30'd0, vga_char_wr, busy}, 32'd0);
        check("mid_rst_outs", {12'd0, vga_char_in, vga_char_x, vga_char_y}, 32'd0);
        check("mid_rst_cursor_drop", {12'd0, cursor_x, cursor_y, drop_cnt}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push_write(8'h5A, 0, 0);
        send(8'h5A);
        repeat (100) @(negedge clk);
        check("post_rst_queue", exp_q.size(), 0);
        check("post_rst_cursor", {20'd0, cursor_x, cursor_y}, {20'd0, 7'd1, 5'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
